mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  MMIO UART transmitter: the TX half of the board serial link; its tx output replaces the tied-high tx pin.
//  CPU pushes bytes through a register window in the 0xFFFF_xxxx MMIO space.
//  Bytes buffer in a FIFO and are serialised 8N1 (LSB first) at a programmable baud divisor.
//  Drives a level interrupt into ext_int when the transmitter drains.
// PARAMETERS
//  FIFO_DEPTH  16   TX FIFO entries; power of 2, >=2
//  DIV_W       16   baud divisor width
//  DIV_RESET   87   reset divisor (clk cycles per bit; 10 MHz cpu_clk -> ~115200 baud)
// PORTS
//  clk     in   1      cpu_clk
//  rst_n   in   1      async active-low reset
//  sel     in   1      top-level decode: access targets this block
//  we      in   1      write strobe (dmem_we & sel)
//  be      in   4      byte strobes (dmem_wstrb)
//  addr    in   4      byte offset; addr[3:2] selects the register
//  wdata   in   32     write data
//  rdata   out  32     read data, combinational; 0 when sel=0
//  tx      out  1      serial line, idle high, registered
//  tx_int  out  1      level IRQ, registered
// BEHAVIOUR
//  Registers (addr[3:2]):
//   0 DATA  W: be[0] pushes wdata[7:0]; reads 0.
//   1 STAT  R: [0] busy (FSM!=IDLE | !empty), [1] full, [2] empty, [3] ovf, [8:4] count. W: be[0] & wdata[3]=1 clears ovf.
//   2 DIV   R/W: [DIV_W-1:0], byte-enabled; reset DIV_RESET; value 0 is treated as 1.
//   3 CTRL  R/W: [0] en (reset 1), [1] irq_en (reset 0), [2] flush (write 1 empties FIFO, self-clearing, reads 0).
//  Reset (async, rst_n=0): tx=1, tx_int=0, FIFO empty, ovf=0, FSM=IDLE, DIV=DIV_RESET, en=1, irq_en=0.
//   Reset mid-frame aborts the frame; tx goes to 1 immediately.
//  FIFO: push to full FIFO is dropped and sets sticky ovf. A same-cycle push and pop with FIFO full accepts the push.
//   Count never exceeds FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
//  Baud tick: counter counts 0..div_lat-1. div_lat latches DIV at frame start.
//   A DIV write mid-frame affects the next frame only.
//  FSM: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP -> IDLE/START.
//   IDLE: if en & !empty, pop on this edge, load shifter, tx<=0, go to START.
//   Each state holds tx for exactly div_lat cycles. DATA shifts LSB first, with a 3-bit bit counter.
//   STOP: tx=1 for div_lat cycles. On exit, if en & !empty, pop and go straight to START (back-to-back, no idle gap).
//  Latency: DATA write to idle empty block -> tx falls 1 clk after the write edge.
//   Frame length = 10*div_lat clks (11 with parity).
//  Clearing en mid-frame completes the current frame, then holds IDLE; FIFO is retained.
//  Flush mid-frame empties the FIFO only; the frame in flight completes.
//  tx_int <= irq_en & empty & (FSM==IDLE), registered (asserts 1 clk after the condition holds).
//  Writes with sel=0 are ignored. Writes with be bits clear leave those bytes unchanged.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: adds CTRL[3] par_odd (reset 0) and a PARITY state between DATA and STOP.
//   The PARITY state transmits even (par_odd=0) or odd parity over the 8 data bits, for div_lat cycles.
//  Undefined: no PARITY state, CTRL[3] reads 0 and ignores writes, frame is 8N1 only.
// TESTING
//  1 Reset: rst_n low mid-frame -> tx=1 same cycle. After release: STAT=0x004, DIV=87, CTRL=0x1, tx_int=0.
//  2 DIV=4, write DATA 0xA5 -> tx: 0 for 4 clk, then bits 1,0,1,0,0,1,0,1 (4 clk each), then 1 for 4 clk.
//    tx falls 1 clk after the write.
//  3 DIV=2, push 0x55 and 0x0F back-to-back -> second start bit begins immediately after first stop (no gap), 40 clk total.
//  4 en=0, push 17 bytes (DEPTH 16) -> STAT full=1, count=16, ovf=1. Write STAT 0x8 -> ovf=0.
//    en=1 -> 16 frames sent, 17th byte absent.
//  5 irq_en=1, push 1 byte at DIV=3 -> tx_int=0 while busy. tx_int=1 exactly 1 clk after STOP ends.
//    tx_int drops once a new byte is pushed.
//  6 (PARITY_EN) DIV=2, par_odd=1, send 0x03 -> parity bit 1. par_odd=0 -> parity bit 0. Frame = 22 clk.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: register window, TX FIFO and 8N1 serialiser with drain IRQ.
// Optional parity frame bit when UART_TX_PARITY_EN is defined (CTRL[3] selects odd parity).
`timescale 1ns/1ps
module mmio_uart_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 87
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        tx_int
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Bus handshake: a write is accepted on any clk edge where sel & we are high;
  // reads are combinational on rdata while sel is high and need no handshake.
  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             ovf, en, irq_en, par_odd, par_acc;
  logic [DIV_W-1:0] div_reg, div_lat, baud_cnt, div_eff, div_mask;
  logic [7:0]       shifter;
  logic [2:0]       bit_cnt;

  logic [1:0] reg_idx;
  logic       wr, push_req, push_ok, pop, flush, ovf_clr, ctrl_wr;
  logic       empty, full, busy, baud_last;
  logic       unused_bits;

  assign reg_idx   = addr[3:2];
  assign wr        = sel & we;
  assign push_req  = wr & (reg_idx == 2'd0) & be[0];
  assign ovf_clr   = wr & (reg_idx == 2'd1) & be[0] & wdata[3];
  assign ctrl_wr   = wr & (reg_idx == 2'd3) & be[0];
  assign flush     = ctrl_wr & wdata[2];
  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign busy      = (state != S_IDLE) | !empty;
  assign baud_last = (baud_cnt == div_lat - 1'b1);
  assign div_eff   = (div_reg == '0) ? DIV_W'(1) : div_reg;
  assign pop       = en & !empty & ((state == S_IDLE) | ((state == S_STOP) & baud_last));
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req & (!full | pop);
  assign unused_bits = ^{addr[1:0], wdata, be};

  always_comb begin
    div_mask = '0;
    for (int i = 0; i < DIV_W; i++) div_mask[i] = be[i/8];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (push_req & !push_ok) ovf <= 1'b1;
      else if (ovf_clr)        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= DIV_W'(DIV_RESET);
      en      <= 1'b1;
      irq_en  <= 1'b0;
      par_odd <= 1'b0;
    end else begin
      if (wr & (reg_idx == 2'd2))
        div_reg <= (div_reg & ~div_mask) | (wdata[DIV_W-1:0] & div_mask);
      if (ctrl_wr) begin
        en     <= wdata[0];
        irq_en <= wdata[1];
`ifdef UART_TX_PARITY_EN
        par_odd <= wdata[3];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      tx_int   <= 1'b0;
      baud_cnt <= '0;
      div_lat  <= DIV_W'(DIV_RESET);
      shifter  <= '0;
      bit_cnt  <= '0;
      par_acc  <= 1'b0;
    end else begin
      tx_int <= irq_en & empty & (state == S_IDLE);
      if (pop) begin
        // Frame start: divisor is sampled here so mid-frame DIV writes wait a frame.
        shifter  <= mem[rd_ptr];
        par_acc  <= ^mem[rd_ptr];
        tx       <= 1'b0;
        baud_cnt <= '0;
        div_lat  <= div_eff;
        state    <= S_START;
      end else if (state != S_IDLE) begin
        if (!baud_last) begin
          baud_cnt <= baud_cnt + 1'b1;
        end else begin
          baud_cnt <= '0;
          case (state)
            S_START: begin
              tx      <= shifter[0];
              shifter <= shifter >> 1;
              bit_cnt <= '0;
              state   <= S_DATA;
            end
            S_DATA: begin
              if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                tx    <= par_acc ^ par_odd;
                state <= S_PARITY;
`else
                tx    <= 1'b1;
                state <= S_STOP;
`endif
              end else begin
                tx      <= shifter[0];
                shifter <= shifter >> 1;
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            S_PARITY: begin
              tx    <= 1'b1;
              state <= S_STOP;
            end
            default: begin
              tx    <= 1'b1;
              state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (reg_idx)
        2'd1: begin
          rdata[0]      = busy;
          rdata[1]      = full;
          rdata[2]      = empty;
          rdata[3]      = ovf;
          rdata[4 +: CW] = count;
        end
        2'd2: rdata[DIV_W-1:0] = div_reg;
        2'd3: begin
          rdata[0] = en;
          rdata[1] = irq_en;
          rdata[3] = par_odd;
        end
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register vector table plus hand-written frame sequences.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_DIV = 4'h8, A_CTRL = 4'hC;

  logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0, we = 1'b0;
  logic [3:0]  be = '0, addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic        tx, tx_int;

  int n_vec = 0, n_bad = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        s;
    logic        w;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t vecs[$];

  mmio_uart_tx dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx(tx), .tx_int(tx_int)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d,
                           input logic s);
    @(negedge clk);
    sel = s; we = 1'b1; addr = a; be = b; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0; be = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic s, output logic [31:0] d);
    @(negedge clk);
    sel = s; we = 1'b0; addr = a;
    #1;
    d = rdata;
    #1;
    sel = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, 1'b1, d);
    check(name, d, exp);
  endtask

  task automatic sample(input int n, input logic exp_tx);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("tx idle", tx, exp_tx);
    end
  endtask

  // scoreboard: pops expected bytes and checks tx every clk of each frame
  task automatic expect_tx(input int d, input int n, input bit par, input bit odd, input bit chk_int);
    logic [7:0]  byt;
    logic [10:0] fr;
    int nb;
    for (int f = 0; f < n; f++) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL scoreboard: expected queue empty");
        return;
      end
      byt = exp_q.pop_front();
      fr = '1;
      fr[0] = 1'b0;
      fr[8:1] = byt;
      if (par) fr[9] = (^byt) ^ odd;
      nb = par ? 11 : 10;
      for (int i = 0; i < nb * d; i++) begin
        @(posedge clk);
        #1;
        check($sformatf("tx byte %02h bit %0d clk %0d", byt, i / d, i), tx, fr[i / d]);
        if (chk_int) check($sformatf("tx_int busy clk %0d", i), tx_int, 1'b0);
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    // reset, then a frame interrupted by reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_write(A_DATA, 4'h1, 32'h00, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("tx start bit before reset", tx, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("tx during async reset", tx, 1'b1);
    check("tx_int during async reset", tx_int, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // register vector table
    vecs.push_back('{1'b1, 1'b0, A_STAT, 4'h0, 32'h0, 32'h004});
    vecs.push_back('{1'b1, 1'b0, A_DIV,  4'h0, 32'h0, 32'd87});
    vecs.push_back('{1'b1, 1'b0, A_CTRL, 4'h0, 32'h0, 32'h1});
    vecs.push_back('{1'b1, 1'b0, A_DATA, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, A_DIV,  4'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, A_DIV,  4'h3, 32'h1234, 32'h0});
    vecs.push_back('{1'b1, 1'b0, A_DIV,  4'h0, 32'h0, 32'h1234});
    vecs.push_back('{1'b1, 1'b1, A_DIV,  4'h1, 32'hFFFF_FF56, 32'h0});
    vecs.push_back('{1'b1, 1'b0, A_DIV,  4'h0, 32'h0, 32'h1256});
    vecs.push_back('{1'b1, 1'b1, A_DIV,  4'h2, 32'h0000_AB00, 32'h0});
    vecs.push_back('{1'b1, 1'b0, A_DIV,  4'h0, 32'h0, 32'hAB56});
    vecs.push_back('{1'b0, 1'b1, A_DIV,  4'hF, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, A_DIV,  4'h0, 32'h0, 32'hAB56});
    vecs.push_back('{1'b1, 1'b1, A_DIV,  4'hC, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b1, 1'b0, A_DIV,  4'h0, 32'h0, 32'hAB56});
    vecs.push_back('{1'b1, 1'b1, A_CTRL, 4'hF, 32'h6, 32'h0});
    vecs.push_back('{1'b1, 1'b0, A_CTRL, 4'h0, 32'h0, 32'h2});
    vecs.push_back('{1'b1, 1'b1, A_CTRL, 4'h0, 32'h1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, A_CTRL, 4'h0, 32'h0, 32'h2});
    vecs.push_back('{1'b1, 1'b1, A_CTRL, 4'hF, 32'hF, 32'h0});
    vecs.push_back('{1'b1, 1'b0, A_CTRL, 4'h0, 32'h0, PAR ? 32'hB : 32'h3});
    vecs.push_back('{1'b1, 1'b1, A_CTRL, 4'hF, 32'h1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, A_CTRL, 4'h0, 32'h0, 32'h1});
    vecs.push_back('{1'b1, 1'b0, A_STAT, 4'h0, 32'h0, 32'h004});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].w) bus_write(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].s);
      else begin
        bus_read(vecs[i].a, vecs[i].s, d);
        check($sformatf("vec %0d rdata", i), d, vecs[i].e);
      end
    end

    // DIV=4, single byte 0xA5
    bus_write(A_DIV, 4'h3, 32'd4, 1'b1);
    exp_q.push_back(8'hA5);
    bus_write(A_DATA, 4'h1, 32'hA5, 1'b1);
    expect_tx(4, 1, PAR, 1'b0, 1'b0);
    sample(2, 1'b1);
    check_reg("stat after A5", A_STAT, 32'h004);

    // DIV=2, back-to-back frames with no idle gap
    bus_write(A_DIV, 4'h3, 32'd2, 1'b1);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    bus_write(A_DATA, 4'h1, 32'h55, 1'b1);
    fork
      bus_write(A_DATA, 4'h1, 32'h0F, 1'b1);
      expect_tx(2, 2, PAR, 1'b0, 1'b0);
    join
    sample(2, 1'b1);

    // DIV write mid-frame only affects the next frame
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h3C);
    bus_write(A_DATA, 4'h1, 32'h81, 1'b1);
    fork
      begin
        repeat (3) @(posedge clk);
        bus_write(A_DIV, 4'h3, 32'd3, 1'b1);
        bus_write(A_DATA, 4'h1, 32'h3C, 1'b1);
      end
      begin
        expect_tx(2, 1, PAR, 1'b0, 1'b0);
        expect_tx(3, 1, PAR, 1'b0, 1'b0);
      end
    join
    sample(2, 1'b1);

    // DIV=0 behaves as 1
    bus_write(A_DIV, 4'h3, 32'd0, 1'b1);
    exp_q.push_back(8'hC6);
    bus_write(A_DATA, 4'h1, 32'hC6, 1'b1);
    expect_tx(1, 1, PAR, 1'b0, 1'b0);
    sample(2, 1'b1);

    // flush on the same edge the first byte starts: frame completes, rest dropped
    bus_write(A_DIV, 4'h3, 32'd2, 1'b1);
    bus_write(A_CTRL, 4'h1, 32'h0, 1'b1);
    bus_write(A_DATA, 4'h1, 32'h11, 1'b1);
    bus_write(A_DATA, 4'h1, 32'h22, 1'b1);
    bus_write(A_DATA, 4'h1, 32'h33, 1'b1);
    check_reg("stat three queued", A_STAT, 32'h031);
    exp_q.push_back(8'h11);
    bus_write(A_CTRL, 4'h1, 32'h1, 1'b1);
    fork
      bus_write(A_CTRL, 4'h1, 32'h5, 1'b1);
      expect_tx(2, 1, PAR, 1'b0, 1'b0);
    join
    sample(4, 1'b1);
    check_reg("stat after flush", A_STAT, 32'h004);
    check_reg("ctrl flush self-clears", A_CTRL, 32'h1);

    // clearing en mid-frame finishes the frame and keeps the FIFO
    exp_q.push_back(8'h5A);
    bus_write(A_DATA, 4'h1, 32'h5A, 1'b1);
    fork
      begin
        bus_write(A_DATA, 4'h1, 32'hA5, 1'b1);
        bus_write(A_CTRL, 4'h1, 32'h0, 1'b1);
      end
      expect_tx(2, 1, PAR, 1'b0, 1'b0);
    join
    sample(6, 1'b1);
    check_reg("stat held by en=0", A_STAT, 32'h011);
    exp_q.push_back(8'hA5);
    bus_write(A_CTRL, 4'h1, 32'h1, 1'b1);
    expect_tx(2, 1, PAR, 1'b0, 1'b0);
    sample(2, 1'b1);

    // overflow: 17 pushes into a 16-entry FIFO, then push on the refill edge
    bus_write(A_CTRL, 4'h1, 32'h0, 1'b1);
    bus_write(A_DIV, 4'h3, 32'd1, 1'b1);
    for (int i = 0; i < 17; i++) bus_write(A_DATA, 4'h1, 32'h10 + i, 1'b1);
    check_reg("stat full+ovf", A_STAT, 32'h10B);
    bus_write(A_STAT, 4'h1, 32'h8, 1'b1);
    check_reg("stat ovf cleared", A_STAT, 32'h103);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'h99);
    bus_write(A_CTRL, 4'h1, 32'h1, 1'b1);
    fork
      bus_write(A_DATA, 4'h1, 32'h99, 1'b1);
      expect_tx(1, 17, PAR, 1'b0, 1'b0);
    join
    sample(3, 1'b1);
    check_reg("stat drained no ovf", A_STAT, 32'h004);

    // drain interrupt timing
    bus_write(A_DIV, 4'h3, 32'd3, 1'b1);
    bus_write(A_CTRL, 4'h1, 32'h3, 1'b1);
    @(posedge clk);
    #1;
    check("tx_int idle empty", tx_int, 1'b1);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(k == 0 ? 8'h4B : 8'hE7);
      bus_write(A_DATA, 4'h1, k == 0 ? 32'h4B : 32'hE7, 1'b1);
      expect_tx(3, 1, PAR, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("tx_int at stop exit", tx_int, 1'b0);
      @(posedge clk);
      #1;
      check("tx_int 1 clk after stop", tx_int, 1'b1);
    end
    bus_write(A_CTRL, 4'h1, 32'h1, 1'b1);
    sample(2, 1'b1);
    check("tx_int irq disabled", tx_int, 1'b0);

`ifdef UART_TX_PARITY_EN
    // parity frames at DIV=2: 0x03 gives odd parity 1, even parity 0
    bus_write(A_DIV, 4'h3, 32'd2, 1'b1);
    bus_write(A_CTRL, 4'h1, 32'h9, 1'b1);
    check_reg("ctrl par_odd", A_CTRL, 32'h9);
    exp_q.push_back(8'h03);
    bus_write(A_DATA, 4'h1, 32'h03, 1'b1);
    expect_tx(2, 1, 1'b1, 1'b1, 1'b0);
    sample(2, 1'b1);
    bus_write(A_CTRL, 4'h1, 32'h1, 1'b1);
    exp_q.push_back(8'h03);
    bus_write(A_DATA, 4'h1, 32'h03, 1'b1);
    expect_tx(2, 1, 1'b1, 1'b0, 1'b0);
    sample(2, 1'b1);
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
